// File: rtl/roi_occupancy_classifier.sv
// ROI occupancy classifier: sums each 3x3 ROI, thresholds it into a per-qubit
// occupied bit, and presents the per-frame bitmap and popcount via valid/ready.
module roi_occupancy_classifier #(
   parameter int unsigned NUM_QUBITS     = 100,
   parameter int unsigned SUM_W          = 12,
   parameter int unsigned ROI_BITS       = 72,
   parameter int unsigned QUBIT_ID_WIDTH = 7,
   parameter int unsigned CNT_W          = $clog2(NUM_QUBITS + 1)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [ROI_BITS-1:0]       i_roi_flat,
   input  logic [QUBIT_ID_WIDTH-1:0] i_qubit_index,
   input  logic                      i_write_enable,
   input  logic                      i_sync_fval,
   input  logic [SUM_W-1:0]          i_threshold,
   output logic [NUM_QUBITS-1:0]     o_occ_map,
   output logic [CNT_W-1:0]          o_occ_count,
   output logic                      o_map_valid,
   input  logic                      i_map_ready,
   output logic                      o_busy,
   output logic                      o_err_dup,
   output logic                      o_err_index,
   output logic                      o_err_overrun
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACQUIRE = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;
   localparam logic [1:0] ST_PRESENT = 2'd3;

   localparam logic [QUBIT_ID_WIDTH-1:0] IDX_LIMIT = QUBIT_ID_WIDTH'(NUM_QUBITS);
   localparam logic [CNT_W-1:0]          CNT_MAX   = CNT_W'(NUM_QUBITS);
   localparam logic [NUM_QUBITS-1:0]     ONE_BIT   = NUM_QUBITS'(1);

   logic [1:0]                state_q, state_d;
   logic                      fval_q;
   logic                      drain_cnt_q;
   logic [SUM_W-1:0]          thr_q;
   logic                      fval_rise, fval_fall;
   logic                      frame_start;
   logic                      accept;

   // Stage 1 registers
   logic                      s1_valid_q;
   logic [QUBIT_ID_WIDTH-1:0] s1_idx_q;
   logic [2:0][9:0]           s1_row_q, s1_row_d;

   // Stage 2 / working state
   logic [NUM_QUBITS-1:0]     map_q;
   logic [NUM_QUBITS-1:0]     seen_q;
   logic [CNT_W-1:0]          count_q;
   logic                      err_dup_q, err_index_q, err_overrun_q;

   logic [SUM_W-1:0]          total;
   logic [NUM_QUBITS-1:0]     dec;
   logic                      idx_ok, is_dup, occ, s2_write;

   assign fval_rise   = i_sync_fval & ~fval_q;
   assign fval_fall   = ~i_sync_fval & fval_q;
   assign frame_start = (state_q == ST_IDLE) && fval_rise;
   // A strobe in the fall cycle is still accepted since state is ACQUIRE then.
   assign accept      = i_write_enable && (state_q == ST_ACQUIRE);

   // Next-state logic for the frame FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (fval_rise) state_d = ST_ACQUIRE;
         ST_ACQUIRE: if (fval_fall) state_d = ST_DRAIN;
         ST_DRAIN:   if (drain_cnt_q) state_d = ST_PRESENT;
         ST_PRESENT: if (i_map_ready) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // FSM state, edge detector, drain timer, threshold latch and overrun flag
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         fval_q        <= 1'b0;
         drain_cnt_q   <= 1'b0;
         thr_q         <= '0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fval_q      <= i_sync_fval;
         drain_cnt_q <= (state_q == ST_DRAIN) ? ~drain_cnt_q : 1'b0;
         if (frame_start) thr_q <= i_threshold;
         // Frame rising during PRESENT is lost; edge detect prevents mid-frame entry later.
         if ((state_q == ST_PRESENT) && fval_rise) err_overrun_q <= 1'b1;
      end
   end

   // Stage 1 combinational row sums (three pixels per row)
   always_comb begin
      s1_row_d = '0;
      for (int r = 0; r < 3; r++) begin
         s1_row_d[r] = 10'(i_roi_flat[24*r +: 8]) + 10'(i_roi_flat[24*r+8 +: 8])
                     + 10'(i_roi_flat[24*r+16 +: 8]);
      end
   end

   // Stage 1 registers: row sums, index and valid
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_idx_q   <= '0;
         s1_row_q   <= '0;
      end else begin
         s1_valid_q <= accept;
         s1_idx_q   <= i_qubit_index;
         s1_row_q   <= s1_row_d;
      end
   end

   // Stage 2 combinational total, threshold compare and drop checks
   always_comb begin
      total    = SUM_W'(s1_row_q[0]) + SUM_W'(s1_row_q[1]) + SUM_W'(s1_row_q[2]);
      dec      = ONE_BIT << s1_idx_q;
      idx_ok   = (s1_idx_q < IDX_LIMIT);
      is_dup   = |(seen_q & dec);
      occ      = (total >= thr_q);
      s2_write = s1_valid_q && idx_ok && !is_dup;
   end

   // Working bitmap, seen mask and popcount; cleared on frame entry
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         map_q   <= '0;
         seen_q  <= '0;
         count_q <= '0;
      end else if (frame_start) begin
         map_q   <= '0;
         seen_q  <= '0;
         count_q <= '0;
      end else if (s2_write) begin
         seen_q <= seen_q | dec;
         if (occ) begin
            map_q <= map_q | dec;
            if (count_q < CNT_MAX) count_q <= count_q + CNT_W'(1);
         end
      end
   end

   // Sticky index and duplicate errors
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         err_dup_q   <= 1'b0;
         err_index_q <= 1'b0;
      end else begin
         if (s1_valid_q && !idx_ok) err_index_q <= 1'b1;
         if (s1_valid_q && idx_ok && is_dup) err_dup_q <= 1'b1;
      end
   end

   assign o_occ_map     = map_q;
   assign o_occ_count   = count_q;
   assign o_map_valid   = (state_q == ST_PRESENT);
   assign o_busy        = (state_q == ST_ACQUIRE) || (state_q == ST_DRAIN);
   assign o_err_dup     = err_dup_q;
   assign o_err_index   = err_index_q;
   assign o_err_overrun = err_overrun_q;

endmodule

// File: tb/tb_roi_occupancy_classifier.sv
// Scoreboard bench for roi_occupancy_classifier: directed frames push expected
// bitmap/count; a negedge monitor pops and compares on each handshake.
module tb_roi_occupancy_classifier;

   logic        clk;
   logic        rst_n;
   logic [71:0] roi_flat;
   logic [6:0]  qidx;
   logic        we;
   logic        fval;
   logic [11:0] thr;
   logic [99:0] occ_map;
   logic [6:0]  occ_count;
   logic        map_valid;
   logic        map_ready;
   logic        busy;
   logic        err_dup, err_index, err_overrun;

   typedef struct {
      logic [99:0] map;
      logic [6:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   roi_occupancy_classifier dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_roi_flat     (roi_flat),
      .i_qubit_index  (qidx),
      .i_write_enable (we),
      .i_sync_fval    (fval),
      .i_threshold    (thr),
      .o_occ_map      (occ_map),
      .o_occ_count    (occ_count),
      .o_map_valid    (map_valid),
      .i_map_ready    (map_ready),
      .o_busy         (busy),
      .o_err_dup      (err_dup),
      .o_err_index    (err_index),
      .o_err_overrun  (err_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [99:0] bitm(input int i);
      logic [99:0] one;
      one = 100'd1;
      return one << i;
   endfunction

   task automatic push(input logic [99:0] m, input logic [6:0] c);
      exp_t e;
      e.map = m;
      e.cnt = c;
      exp_q.push_back(e);
   endtask

   // Monitor: compare on every accepted presentation
   always @(negedge clk) begin
      if (rst_n && map_valid && map_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_map: got map %h count %0d, expected no presentation",
                     occ_map, occ_count);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("map", 128'(occ_map), 128'(e.map));
            chk("count", 128'(occ_count), 128'(e.cnt));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic frame_begin(input logic [11:0] t);
      thr  = t;
      fval = 1'b1;
      tick();
   endtask

   task automatic frame_end;
      fval = 1'b0;
      tick();
   endtask

   task automatic roi(input logic [71:0] r, input logic [6:0] i);
      roi_flat = r;
      qidx     = i;
      we       = 1'b1;
      tick();
      we       = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      chk(name, 128'(exp_q.size()), 128'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_map"}, 128'(occ_map), 128'd0);
      chk({tag, "_count"}, 128'(occ_count), 128'd0);
      chk({tag, "_valid"}, 128'(map_valid), 128'd0);
      chk({tag, "_busy"}, 128'(busy), 128'd0);
      chk({tag, "_errs"}, 128'({err_dup, err_index, err_overrun}), 128'd0);
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      roi_flat  = '0;
      qidx      = '0;
      we        = 1'b0;
      fval      = 1'b0;
      thr       = '0;
      map_ready = 1'b1;
      tick();
      tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // T1: basic threshold
      push(bitm(3), 7'd1);
      frame_begin(12'd1000);
      chk("t1_busy", 128'(busy), 128'd1);
      roi({9{8'd200}}, 7'd3);
      roi({9{8'd100}}, 7'd7);
      frame_end();
      wait_drain("t1_done");
      chk("t1_no_err", 128'({err_dup, err_index, err_overrun}), 128'd0);

      // T2: boundary at 2295
      push(bitm(10), 7'd1);
      frame_begin(12'd2295);
      roi({9{8'd255}}, 7'd10);
      roi({{8{8'd255}}, 8'd254}, 7'd11);
      frame_end();
      wait_drain("t2_done");

      // T3: duplicate (first wins) and out-of-range index
      push(bitm(5), 7'd1);
      frame_begin(12'd1000);
      roi({{8{8'd250}}, 8'd0}, 7'd5);
      roi({9{8'd0}}, 7'd5);
      roi({9{8'd255}}, 7'd120);
      frame_end();
      wait_drain("t3_done");
      chk("t3_err_dup", 128'(err_dup), 128'd1);
      chk("t3_err_index", 128'(err_index), 128'd1);
      chk("t3_err_overrun", 128'(err_overrun), 128'd0);

      // T4: overrun while presenting
      map_ready = 1'b0;
      push(bitm(20), 7'd1);
      frame_begin(12'd1000);
      roi({9{8'd200}}, 7'd20);
      frame_end();
      n = 0;
      while (!map_valid && n < 20) begin
         tick();
         n++;
      end
      chk("t4_valid", 128'(map_valid), 128'd1);
      frame_begin(12'd1000);
      roi({9{8'd200}}, 7'd21);
      frame_end();
      tick();
      tick();
      tick();
      chk("t4_overrun", 128'(err_overrun), 128'd1);
      chk("t4_map_held", 128'(occ_map), 128'(bitm(20)));
      chk("t4_count_held", 128'(occ_count), 128'd1);
      chk("t4_valid_held", 128'(map_valid), 128'd1);
      map_ready = 1'b1;
      wait_drain("t4_handshake");
      tick();
      push(bitm(30), 7'd1);
      frame_begin(12'd1000);
      roi({9{8'd200}}, 7'd30);
      frame_end();
      wait_drain("t4_next");

      // T5: 100 back-to-back strobes, last one on the fval fall
      push({100{1'b1}}, 7'd100);
      frame_begin(12'd100);
      for (int i = 0; i < 100; i++) begin
         roi_flat = {9{8'd50}};
         qidx     = 7'(i);
         we       = 1'b1;
         if (i == 99) fval = 1'b0;
         tick();
      end
      we = 1'b0;
      wait_drain("t5_done");

      // T6: reset mid-acquire
      frame_begin(12'd100);
      roi({9{8'd200}}, 7'd1);
      roi({9{8'd200}}, 7'd2);
      rst_n = 1'b0;
      tick();
      chk_all_zero("t6");
      rst_n = 1'b1;
      fval  = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("t6_no_valid", 128'(map_valid), 128'd0);
      chk("t6_map", 128'(occ_map), 128'd0);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
